store_buffer: RTL and testbench

//  Posted-write FIFO between the core's load/store path and data_memory.

---
 rtl/store_buffer_pkg.sv | 27 ++
 rtl/sb_conflict_check.sv | 26 ++
 rtl/store_buffer.sv | 100 ++++++++++
 tb/tb_store_buffer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: access-size encodings, the buffer
// entry layout and the helper that finds the last byte an access touches.
package store_buffer_pkg;

  localparam int SB_ADDR_WIDTH = 32;
  localparam int SB_DATA_WIDTH = 32;

  // load_store_type encodings; the byte count of an access is type + 1.
  localparam logic [1:0] LS_BYTE = 2'd0;
  localparam logic [1:0] LS_HALF = 2'd1;
  localparam logic [1:0] LS_WORD = 2'd3;

  typedef struct packed {
    logic [SB_ADDR_WIDTH-1:0] addr;
    logic [SB_DATA_WIDTH-1:0] data;
    logic [1:0]               ls_type;
    logic                     valid;
  } sb_entry_t;

  function automatic logic [SB_ADDR_WIDTH-1:0] last_byte(
    input logic [SB_ADDR_WIDTH-1:0] addr,
    input logic [1:0]               ls_type
  );
    return addr + {{(SB_ADDR_WIDTH-2){1'b0}}, ls_type};
  endfunction

endpackage

// File: rtl/sb_conflict_check.sv
// Word-granular overlap test between one buffer entry and the incoming load.
// Both spans are at most two words, so endpoint equality is a full overlap test.
module sb_conflict_check
  import store_buffer_pkg::*;
(
  input  sb_entry_t                entry,
  input  logic [SB_ADDR_WIDTH-1:0] ld_addr,
  input  logic [1:0]               ld_type,
  output logic                     hit
);

  logic [SB_ADDR_WIDTH-1:0] ld_first;
  logic [SB_ADDR_WIDTH-1:0] ld_last;
  logic [SB_ADDR_WIDTH-1:0] st_first;
  logic [SB_ADDR_WIDTH-1:0] st_last;

  assign ld_first = ld_addr >> 2;
  assign ld_last  = last_byte(ld_addr, ld_type) >> 2;
  assign st_first = entry.addr >> 2;
  assign st_last  = last_byte(entry.addr, entry.ls_type) >> 2;

  assign hit = entry.valid &&
               ((ld_first == st_first) || (ld_first == st_last) ||
                (ld_last  == st_first) || (ld_last  == st_last));

endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO between the core load/store path and data_memory.
// Loads own the memory port unless they hit a pending store, in which case the buffer drains.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH = SB_ADDR_WIDTH,
  parameter int DATA_WIDTH = SB_DATA_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  st_valid,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic [1:0]            st_type,
  output logic                  st_ready,
  input  logic                  ld_req,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [1:0]            ld_type,
  output logic                  ld_stall,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [1:0]            load_store_type,
  output logic                  empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  sb_entry_t        entries [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [DEPTH-1:0] hits;
  logic             accept;
  logic             drain;
  logic             load_grant;

  for (genvar g = 0; g < DEPTH; g++) begin : g_chk
    sb_conflict_check u_chk (
      .entry   (entries[g]),
      .ld_addr (ld_addr),
      .ld_type (ld_type),
      .hit     (hits[g])
    );
  end

  // Full is not relaxed by a same-cycle drain, keeping st_ready off the drain path.
  assign st_ready   = (count != FULL_COUNT);
  assign empty      = (count == '0);
  assign accept     = st_valid && st_ready;
  assign ld_stall   = ld_req && (|hits);
  assign load_grant = ld_req && !ld_stall;
  assign drain      = !load_grant && !empty;

  // NOTE: every output gets a default before the branches, so no latch can be inferred.
  always_comb begin
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_addr        = '0;
    mem_write_data  = '0;
    load_store_type = 2'b00;
    if (load_grant) begin
      mem_read        = 1'b1;
      mem_addr        = ld_addr;
      load_store_type = ld_type;
    end else if (drain) begin
      mem_write       = 1'b1;
      mem_addr        = entries[rd_ptr].addr;
      mem_write_data  = entries[rd_ptr].data;
      load_store_type = entries[rd_ptr].ls_type;
    end
  end

  // NOTE: state uses non-blocking assignments so every read sees the pre-edge value.
  // NOTE: only the valid bits are reset; the payload is never read while invalid.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i].valid <= 1'b0;
    end else begin
      if (accept) begin
        entries[wr_ptr] <= '{addr: st_addr, data: st_data, ls_type: st_type, valid: 1'b1};
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (drain) begin
        entries[rd_ptr].valid <= 1'b0;
        rd_ptr                <= rd_ptr + 1'b1;
      end
      if (accept && !drain)      count <= count + 1'b1;
      else if (drain && !accept) count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: a queue-level model checked every cycle,
// plus a byte-addressed memory fed by the DUT's write port for literal checks.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam logic [1:0] T_BYTE = 2'd0;
  localparam logic [1:0] T_HALF = 2'd1;
  localparam logic [1:0] T_WORD = 2'd3;

  logic        clk;
  logic        rstn;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_type;
  logic        st_ready;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [1:0]  ld_type;
  logic        ld_stall;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  load_store_type;
  logic        empty;

  store_buffer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .st_valid        (st_valid),
    .st_addr         (st_addr),
    .st_data         (st_data),
    .st_type         (st_type),
    .st_ready        (st_ready),
    .ld_req          (ld_req),
    .ld_addr         (ld_addr),
    .ld_type         (ld_type),
    .ld_stall        (ld_stall),
    .mem_addr        (mem_addr),
    .mem_write_data  (mem_write_data),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .load_store_type (load_store_type),
    .empty           (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Model: pending stores in accept order.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  t;
  } st_t;
  st_t q[$];
  bit  model_live = 0;

  // Memory as seen from the DUT write port, plus the order of written addresses.
  logic [7:0]  dut_mem [logic [31:0]];
  logic [31:0] write_log[$];

  function automatic bit words_overlap(input logic [31:0] a, input logic [1:0] at,
                                       input logic [31:0] b, input logic [1:0] bt);
    for (int i = 0; i <= int'(at); i++)
      for (int j = 0; j <= int'(bt); j++)
        if (((a + 32'(i)) >> 2) == ((b + 32'(j)) >> 2)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_stall();
    if (!ld_req) return 1'b0;
    foreach (q[i]) if (words_overlap(ld_addr, ld_type, q[i].addr, q[i].t)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] dut_word(input logic [31:0] a);
    logic [31:0] w = '0;
    for (int b = 0; b < 4; b++)
      if (dut_mem.exists(a + 32'(b))) w[8*b +: 8] = dut_mem[a + 32'(b)];
    return w;
  endfunction

  // Compare process: outputs are settled mid-cycle.
  always @(negedge clk) begin
    if (model_live) begin
      automatic bit stall = model_stall();
      automatic bit grant = ld_req && !stall;
      check("st_ready", st_ready, q.size() != DEPTH);
      check("empty", empty, q.size() == 0);
      check("ld_stall", ld_stall, stall);
      if (grant) begin
        check("rd.mem_read", mem_read, 1);
        check("rd.mem_write", mem_write, 0);
        check("rd.mem_addr", mem_addr, ld_addr);
        check("rd.type", load_store_type, ld_type);
      end else if (q.size() > 0) begin
        check("wr.mem_read", mem_read, 0);
        check("wr.mem_write", mem_write, 1);
        check("wr.mem_addr", mem_addr, q[0].addr);
        check("wr.data", mem_write_data, q[0].data);
        check("wr.type", load_store_type, q[0].t);
      end else begin
        check("idle.mem_read", mem_read, 0);
        check("idle.mem_write", mem_write, 0);
        check("idle.mem_addr", mem_addr, 0);
        check("idle.data", mem_write_data, 0);
        check("idle.type", load_store_type, 0);
      end
    end
    if (mem_write === 1'b1) begin
      for (int b = 0; b <= int'(load_store_type); b++)
        dut_mem[mem_addr + 32'(b)] = mem_write_data[8*b +: 8];
      write_log.push_back(mem_addr);
    end
  end

  // Model update at the active edge.
  always @(posedge clk) begin
    if (!rstn) begin
      q.delete();
      model_live <= 1'b1;
    end else if (model_live) begin
      automatic bit stall = model_stall();
      automatic bit grant = ld_req && !stall;
      automatic bit acc   = st_valid && (q.size() != DEPTH);
      automatic bit drn   = !grant && (q.size() > 0);
      if (drn) void'(q.pop_front());
      if (acc) q.push_back('{addr: st_addr, data: st_data, t: st_type});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_type  = t;
  endtask

  initial begin
    rstn = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_type = '0;
    ld_req = 1'b0; ld_addr = '0; ld_type = '0;
    step(); step();
    rstn = 1'b1;
    #1;
    check("reset.st_ready", st_ready, 1);
    check("reset.empty", empty, 1);
    check("reset.mem_write", mem_write, 0);
    check("reset.ld_stall", ld_stall, 0);

    // 1: four back-to-back word stores, no loads.
    write_log.delete();
    for (int i = 0; i < 4; i++) begin
      store(32'h40 + 32'(4 * i), (i == 0) ? 32'hDEADBEEF : 32'h0101_0101 * 32'(i + 1), T_WORD);
      step();
    end
    st_valid = 1'b0;
    repeat (5) step();
    check("t1.nwrites", write_log.size(), 4);
    for (int i = 0; i < 4 && i < write_log.size(); i++)
      check("t1.order", write_log[i], 32'h40 + 32'(4 * i));
    check("t1.word40", dut_word(32'h40), 32'hDEADBEEF);
    check("t1.word4c", dut_word(32'h4C), 32'h0404_0404);
    check("t1.empty", empty, 1);

    // 2: store then overlapping load stalls one cycle.
    store(32'h40, 32'h11223344, T_WORD);
    step();
    st_valid = 1'b0;
    ld_req = 1'b1; ld_addr = 32'h40; ld_type = T_WORD;
    #1 check("t2.stall_on", ld_stall, 1);
    step();
    check("t2.stall_off", ld_stall, 0);
    check("t2.mem_read", mem_read, 1);
    check("t2.load_data", dut_word(mem_addr), 32'h11223344);
    step();
    ld_req = 1'b0;
    step();

    // 3: byte store vs half loads in a neighbouring and the same word.
    store(32'h43, 32'h000000AA, T_BYTE);
    step();
    st_valid = 1'b0;
    ld_req = 1'b1; ld_addr = 32'h44; ld_type = T_HALF;
    #1 check("t3.no_stall", ld_stall, 0);
    ld_addr = 32'h42;
    #1 check("t3.stall", ld_stall, 1);
    step();
    check("t3.released", ld_stall, 0);
    check("t3.word40", dut_word(32'h40), 32'hAA223344);
    step();
    ld_req = 1'b0;
    step();

    // 4: fill under a load stream, one rejected extra store, then drain.
    write_log.delete();
    ld_req = 1'b1; ld_addr = 32'h80; ld_type = T_WORD;
    for (int i = 0; i < DEPTH; i++) begin
      store(32'h90 + 32'(4 * i), 32'hA0 + 32'(i), T_WORD);
      step();
    end
    check("t4.full", st_ready, 0);
    store(32'hA0, 32'hBAD, T_WORD);
    step();
    check("t4.no_drain", write_log.size(), 0);
    st_valid = 1'b0; ld_req = 1'b0;
    repeat (DEPTH + 2) step();
    check("t4.nwrites", write_log.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < write_log.size(); i++)
      check("t4.order", write_log[i], 32'h90 + 32'(4 * i));
    check("t4.word9c", dut_word(32'h9C), 32'hA3);
    check("t4.ready", st_ready, 1);

    // 5: accept and drain on the same edge at count 2.
    ld_req = 1'b1;
    store(32'hC0, 32'h1, T_WORD); step();
    store(32'hC4, 32'h2, T_WORD); step();
    ld_req = 1'b0;
    store(32'hC8, 32'h3, T_WORD); step();
    st_valid = 1'b0;
    check("t5.ready", st_ready, 1);
    step();
    check("t5.one_left", empty, 0);
    step();
    check("t5.drained", empty, 1);
    check("t5.wordc8", dut_word(32'hC8), 32'h3);

    // 6: reset with three pending stores discards them.
    ld_req = 1'b1; ld_addr = 32'h80;
    for (int i = 0; i < 3; i++) begin
      store(32'hB0 + 32'(4 * i), 32'h5A5A0000 + 32'(i), T_WORD);
      step();
    end
    st_valid = 1'b0;
    rstn = 1'b0;
    step();
    rstn = 1'b1; ld_req = 1'b0;
    #1 check("t6.empty", empty, 1);
    write_log.delete();
    repeat (4) step();
    check("t6.no_writes", write_log.size(), 0);
    check("t6.wordb0", dut_word(32'hB0), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
